// File: rtl/pipeline_control.sv
// pipeline_control
//   Hazard and sequencing controller for the five-stage ARMv8 pipeline.
//   Generates the PC-write enable and branch-select for fetch, the stall,
//   bubble and flush controls for IF/ID, ID/EX and EX/MEM, sequences the
//   post-reset boot delay and the drain-and-halt on HLT, and keeps
//   saturating stall / flush statistics.
//
// Parameters
//   BOOT_CYCLES  cycles after reset release before the first PC update (>=1)
//   DRAIN_CYCLES cycles given to older instructions after HLT reaches ID (>=1)
//   CNT_W        width of the statistics counters
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   idex_memread   instruction in EX is a load
//   idex_rd        destination register of the instruction in EX
//   ifid_rn/rm     source registers of the instruction in ID
//   ifid_rm_valid  instruction in ID reads ifid_rm
//   ifid_halt      instruction in ID is HLT
//   branch_taken   taken branch resolved in EX/MEM
//   pc_write       PC load enable
//   Branchreg      fetch PC mux select (1 = branch target)
//   ifid_write     IF/ID load enable
//   ifid_flush     IF/ID cleared to NOP
//   idex_bubble    ID/EX loaded with a bubble
//   exmem_flush    EX/MEM control cleared
//   halted         pipeline drained and stopped (registered state decode)
//   stall_count    saturating count of load-use stall cycles
//   flush_count    saturating count of taken-branch flush events
module pipeline_control #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rn,
    input  logic [4:0]       ifid_rm,
    input  logic             ifid_rm_valid,
    input  logic             ifid_halt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             Branchreg,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    // One shared cycle counter serves both the boot delay and the drain window.
    localparam int MAXC = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BOOT_LAST  = CW'(BOOT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             hazard;
    logic             stall_inc;
    logic             flush_inc;

    // XZR (X31) is never a real producer, so it cannot create a hazard.
    assign hazard = idex_memread && (idex_rd != 5'd31) &&
                    ((idex_rd == ifid_rn) || (ifid_rm_valid && (idex_rd == ifid_rm)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_write    = 1'b0;
        Branchreg   = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;

        case (state_q)
            BOOT: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    Branchreg   = 1'b1;
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (hazard) begin
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (ifid_halt) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = '0;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    // HLT was fetched down the wrong path: redirect and resume.
                    Branchreg   = 1'b1;
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = RUN;
                    cnt_d       = '0;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = HALTED;
                        cnt_d   = '0;
                    end
                end
            end
            HALTED: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end
            default: begin
                state_d = BOOT;
                cnt_d   = '0;
            end
        endcase

        // While reset is held, the pipeline sees the boot controls immediately.
        if (!reset) begin
            pc_write    = 1'b0;
            Branchreg   = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end

        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush_inc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted      = (state_q == HALTED);
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule
